// File: rtl/cv32e40s_pkg.sv
// Shared types for the illegal-instruction tracer.
// Optional feature macro: CV32E40S_TRACE_INSTR_EN adds the instruction word to each record.
package cv32e40s_pkg;

   localparam int unsigned ILLEGAL_SEQ_W   = 16;
   localparam int unsigned ILLEGAL_CYCLE_W = 32;

   // Record layout at the default cycle-stamp width. The tracer builds the same
   // shape locally so it can follow a non-default CYCLE_W.
   typedef struct packed {
      logic [31:0]                  pc;
      logic [ILLEGAL_CYCLE_W-1:0]   cycle;
      logic [ILLEGAL_SEQ_W-1:0]     seq;
`ifdef CV32E40S_TRACE_INSTR_EN
      logic [31:0]                  instr;
`endif
   } illegal_rec_t;

endpackage

// File: rtl/cv32e40s_rec_fifo.sv
// Generic synchronous FIFO with one extra pointer bit to tell full from empty.
// Flush has priority over push and pop. Storage is not reset; the consumer
// qualifies the head with empty.
module cv32e40s_rec_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter type         T     = logic [31:0]
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush,
   input  logic push,
   input  logic pop,
   input  T     wdata,
   output T     rdata,
   output logic full,
   output logic empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0] wptr;
   logic [AW:0] rptr;
   logic        do_push;
   logic        do_pop;
   T            mem [DEPTH];

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   // A full FIFO may still accept when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rptr[AW-1:0]];

   // Pointer update: reset and flush both empty the FIFO.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + (AW + 1)'(1);
         if (do_pop)  rptr <= rptr + (AW + 1)'(1);
      end
   end

   // Entry write; the head is read combinationally before the slot is reused.
   always_ff @(posedge clk) begin
      if (rst_n && !flush && do_push) begin
         mem[wptr[AW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/cv32e40s_illegal_insn_tracer.sv
// Captures illegal instructions retiring in WB as {pc, cycle, seq} records and
// streams them out over valid/ready. Drops on a full FIFO are counted, never silent.
// Optional feature macro: CV32E40S_TRACE_INSTR_EN stores wb_instr_i per record.
module cv32e40s_illegal_insn_tracer
   import cv32e40s_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned CYCLE_W = 32,
   parameter int unsigned DROP_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wb_valid_i,
   input  logic                     wb_illegal_i,
   input  logic [31:0]              wb_pc_i,
   input  logic [31:0]              wb_instr_i,
   input  logic                     clear_i,
   output logic                     rec_valid_o,
   input  logic                     rec_ready_i,
   output logic [31:0]              rec_pc_o,
   output logic [CYCLE_W-1:0]       rec_cycle_o,
   output logic [ILLEGAL_SEQ_W-1:0] rec_seq_o,
   output logic [31:0]              rec_instr_o,
   output logic [DROP_W-1:0]        drop_cnt_o,
   output logic                     overflow_o
);

   typedef struct packed {
      logic [31:0]              pc;
      logic [CYCLE_W-1:0]       cycle;
      logic [ILLEGAL_SEQ_W-1:0] seq;
`ifdef CV32E40S_TRACE_INSTR_EN
      logic [31:0]              instr;
`endif
   } rec_t;

   logic [CYCLE_W-1:0]       cycle_cnt;
   logic [ILLEGAL_SEQ_W-1:0] seq_cnt;
   logic [DROP_W-1:0]        drop_cnt;
   logic                     overflow;

   logic capture;
   logic rec_valid;
   logic pop;
   logic push;
   logic drop;
   logic full;
   logic empty;
   rec_t wr_rec;
   rec_t rd_rec;

   assign capture   = wb_valid_i & wb_illegal_i;
   assign rec_valid = ~empty;
   assign pop       = rec_valid & rec_ready_i & ~clear_i;
   // A capture coinciding with clear is discarded outright, not counted as a drop.
   assign push      = capture & ~clear_i & (~full | pop);
   assign drop      = capture & ~clear_i & full & ~pop;

   assign wr_rec.pc    = wb_pc_i;
   assign wr_rec.cycle = cycle_cnt;
   assign wr_rec.seq   = seq_cnt;
`ifdef CV32E40S_TRACE_INSTR_EN
   assign wr_rec.instr = wb_instr_i;
`else
   logic unused_instr;
   assign unused_instr = ^wb_instr_i;
`endif

   cv32e40s_rec_fifo #(
      .DEPTH (DEPTH),
      .T     (rec_t)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (clear_i),
      .push  (push),
      .pop   (pop),
      .wdata (wr_rec),
      .rdata (rd_rec),
      .full  (full),
      .empty (empty)
   );

   // Free-running cycle stamp; clear_i deliberately leaves it alone.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cycle_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + CYCLE_W'(1);
      end
   end

   // Sequence number advances on every capture, kept or lost, so gaps expose losses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seq_cnt <= '0;
      end else if (capture) begin
         seq_cnt <= seq_cnt + ILLEGAL_SEQ_W'(1);
      end
   end

   // Saturating drop counter and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (!rst_n || clear_i) begin
         drop_cnt <= '0;
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (drop_cnt != {DROP_W{1'b1}}) begin
            drop_cnt <= drop_cnt + DROP_W'(1);
         end
      end
   end

   // Head fields are masked while empty so stale storage never shows on the port.
   always_comb begin
      rec_valid_o = rec_valid;
      rec_pc_o    = '0;
      rec_cycle_o = '0;
      rec_seq_o   = '0;
      rec_instr_o = '0;
      if (rec_valid) begin
         rec_pc_o    = rd_rec.pc;
         rec_cycle_o = rd_rec.cycle;
         rec_seq_o   = rd_rec.seq;
`ifdef CV32E40S_TRACE_INSTR_EN
         rec_instr_o = rd_rec.instr;
`endif
      end
   end

   assign drop_cnt_o = drop_cnt;
   assign overflow_o = overflow;

endmodule

// File: tb/tb_cv32e40s_illegal_insn_tracer.sv
// Self-checking bench for the illegal-instruction tracer. A narrow cycle stamp
// and drop counter make wrap and saturation reachable in a short run.
module tb_cv32e40s_illegal_insn_tracer;

   localparam int unsigned DEPTH    = 4;
   localparam int unsigned CYCLE_W  = 8;
   localparam int unsigned DROP_W   = 4;
   localparam int unsigned DROP_MAX = (1 << DROP_W) - 1;
`ifdef CV32E40S_TRACE_INSTR_EN
   localparam bit INSTR_EN = 1'b1;
`else
   localparam bit INSTR_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst_n;
   logic               wb_valid;
   logic               wb_illegal;
   logic [31:0]        wb_pc;
   logic [31:0]        wb_instr;
   logic               clear;
   logic               rec_ready;
   logic               rec_valid;
   logic [31:0]        rec_pc;
   logic [CYCLE_W-1:0] rec_cycle;
   logic [15:0]        rec_seq;
   logic [31:0]        rec_instr;
   logic [DROP_W-1:0]  drop_cnt;
   logic               overflow;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   cv32e40s_illegal_insn_tracer #(
      .DEPTH   (DEPTH),
      .CYCLE_W (CYCLE_W),
      .DROP_W  (DROP_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wb_valid_i   (wb_valid),
      .wb_illegal_i (wb_illegal),
      .wb_pc_i      (wb_pc),
      .wb_instr_i   (wb_instr),
      .clear_i      (clear),
      .rec_valid_o  (rec_valid),
      .rec_ready_i  (rec_ready),
      .rec_pc_o     (rec_pc),
      .rec_cycle_o  (rec_cycle),
      .rec_seq_o    (rec_seq),
      .rec_instr_o  (rec_instr),
      .drop_cnt_o   (drop_cnt),
      .overflow_o   (overflow)
   );

   // Reference model: a queue of records plus plain counters.
   typedef struct {
      int unsigned pc;
      int unsigned cyc;
      int unsigned seq;
      int unsigned instr;
   } mrec_t;

   mrec_t       mq[$];
   int unsigned m_cycle = 0;
   int unsigned m_seq   = 0;
   int unsigned m_drop  = 0;
   bit          m_ovf   = 1'b0;

   task automatic model_edge();
      bit    cap;
      bit    popd;
      bit    was_full;
      mrec_t r;
      if (!rst_n) begin
         mq.delete();
         m_cycle = 0;
         m_seq   = 0;
         m_drop  = 0;
         m_ovf   = 1'b0;
         return;
      end
      cap      = wb_valid && wb_illegal;
      popd     = (mq.size() > 0) && rec_ready;
      was_full = (mq.size() == DEPTH);
      if (clear) begin
         mq.delete();
         m_drop = 0;
         m_ovf  = 1'b0;
      end else begin
         if (popd) void'(mq.pop_front());
         if (cap) begin
            if (!was_full || popd) begin
               r.pc    = wb_pc;
               r.cyc   = m_cycle;
               r.seq   = m_seq;
               r.instr = INSTR_EN ? wb_instr : 32'h0;
               mq.push_back(r);
            end else begin
               if (m_drop < DROP_MAX) m_drop++;
               m_ovf = 1'b1;
            end
         end
      end
      if (cap) m_seq = (m_seq + 1) % 65536;
      m_cycle = (m_cycle + 1) % (1 << CYCLE_W);
   endtask

   // One clock: inputs are already set, model follows the edge, sample 1 time unit later.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      wb_valid   = 1'b0;
      wb_illegal = 1'b0;
      wb_pc      = 32'h0;
      wb_instr   = 32'h0;
      clear      = 1'b0;
      rec_ready  = 1'b0;
   endtask

   task automatic drive_cap(input logic [31:0] pc, input logic [31:0] instr);
      wb_valid   = 1'b1;
      wb_illegal = 1'b1;
      wb_pc      = pc;
      wb_instr   = instr;
   endtask

   task automatic no_cap();
      wb_valid   = 1'b0;
      wb_illegal = 1'b0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      wb_pc = 32'hFFFF_FFFF;
      rst_n = 1'b0;
      step();
      step();
      n_checks++;
      if (rec_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rec_valid);
      else n_pass++;
      n_checks++;
      if ({rec_pc, rec_cycle, rec_seq, rec_instr} !== '0)
         $display("FAIL reset_rec: got pc %h cyc %h seq %h instr %h want all 0",
                  rec_pc, rec_cycle, rec_seq, rec_instr);
      else n_pass++;
      n_checks++;
      if (drop_cnt !== '0 || overflow !== 1'b0)
         $display("FAIL reset_drop: got drop %0d ovf %b want 0/0", drop_cnt, overflow);
      else n_pass++;
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      apply_reset();
      step(); step(); step(); step(); step();
      drive_cap(32'h0000_0100, 32'hCAFE_0001);
      n_checks++;
      if (rec_valid !== 1'b0) $display("FAIL single_nobypass: got %b want 0", rec_valid);
      else n_pass++;
      step();
      no_cap();
      n_checks++;
      if (rec_valid !== 1'b1 || rec_pc !== 32'h100 || rec_cycle !== 8'd5 || rec_seq !== 16'd0)
         $display("FAIL single_rec: got v %b pc %h cyc %0d seq %0d want 1 100 5 0",
                  rec_valid, rec_pc, rec_cycle, rec_seq);
      else n_pass++;
      rec_ready = 1'b1;
      step();
      rec_ready = 1'b0;
      n_checks++;
      if (rec_valid !== 1'b0) $display("FAIL single_pop: got %b want 0", rec_valid);
      else n_pass++;
   endtask

   task automatic test_overflow();
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         drive_cap(32'h1000 + 4 * i, 32'h0);
         step();
      end
      no_cap();
      n_checks++;
      if (drop_cnt !== 4'd2 || overflow !== 1'b1 || rec_valid !== 1'b1)
         $display("FAIL ovf_state: got drop %0d ovf %b v %b want 2 1 1",
                  drop_cnt, overflow, rec_valid);
      else n_pass++;
      rec_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (rec_valid !== 1'b1 || rec_seq !== 16'(k) || rec_pc !== 32'(32'h1000 + 4 * k))
            $display("FAIL ovf_drain%0d: got v %b seq %0d pc %h want 1 %0d %h",
                     k, rec_valid, rec_seq, rec_pc, k, 32'h1000 + 4 * k);
         else n_pass++;
         step();
      end
      rec_ready = 1'b0;
      n_checks++;
      if (rec_valid !== 1'b0 || drop_cnt !== 4'd2 || overflow !== 1'b1)
         $display("FAIL ovf_empty: got v %b drop %0d ovf %b want 0 2 1",
                  rec_valid, drop_cnt, overflow);
      else n_pass++;
   endtask

   task automatic test_full_pushpop();
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         drive_cap(32'h2000 + 4 * i, 32'h0);
         step();
      end
      drive_cap(32'h3000, 32'h0);
      rec_ready = 1'b1;
      step();
      rec_ready = 1'b0;
      n_checks++;
      if (drop_cnt !== 4'd0 || rec_seq !== 16'd1)
         $display("FAIL full_pp: got drop %0d seq %0d want 0 1", drop_cnt, rec_seq);
      else n_pass++;
      drive_cap(32'h3004, 32'h0);
      step();
      no_cap();
      n_checks++;
      if (drop_cnt !== 4'd1 || overflow !== 1'b1)
         $display("FAIL full_still: got drop %0d ovf %b want 1 1", drop_cnt, overflow);
      else n_pass++;
      rec_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         n_checks++;
         if (rec_valid !== 1'b1 || rec_seq !== 16'(k))
            $display("FAIL full_drain%0d: got v %b seq %0d want 1 %0d", k, rec_valid, rec_seq, k);
         else n_pass++;
         if (k == 4) begin
            n_checks++;
            if (rec_pc !== 32'h3000) $display("FAIL full_newpc: got %h want 3000", rec_pc);
            else n_pass++;
         end
         step();
      end
      rec_ready = 1'b0;
   endtask

   task automatic test_legal_only();
      apply_reset();
      wb_valid   = 1'b1;
      wb_illegal = 1'b0;
      for (int i = 0; i < 100; i++) begin
         wb_pc = $urandom;
         step();
      end
      n_checks++;
      if (rec_valid !== 1'b0 || drop_cnt !== 4'd0)
         $display("FAIL legal_none: got v %b drop %0d want 0 0", rec_valid, drop_cnt);
      else n_pass++;
      drive_cap(32'h400, 32'h0);
      step();
      no_cap();
      n_checks++;
      if (rec_valid !== 1'b1 || rec_seq !== 16'd0)
         $display("FAIL legal_seq: got v %b seq %0d want 1 0", rec_valid, rec_seq);
      else n_pass++;
   endtask

   task automatic test_saturate();
      apply_reset();
      for (int i = 0; i < 24; i++) begin
         drive_cap(32'h500 + i, 32'h0);
         step();
      end
      no_cap();
      n_checks++;
      if (drop_cnt !== 4'd15 || overflow !== 1'b1)
         $display("FAIL sat_drop: got drop %0d ovf %b want 15 1", drop_cnt, overflow);
      else n_pass++;
   endtask

   task automatic test_clear();
      apply_reset();
      for (int i = 0; i < 11; i++) begin
         drive_cap(32'h600 + i, 32'h0);
         step();
      end
      no_cap();
      rec_ready = 1'b1;
      step();
      rec_ready = 1'b0;
      n_checks++;
      if (drop_cnt !== 4'd7 || rec_seq !== 16'd1)
         $display("FAIL clr_pre: got drop %0d seq %0d want 7 1", drop_cnt, rec_seq);
      else n_pass++;
      clear = 1'b1;
      drive_cap(32'h700, 32'h0);
      step();
      clear = 1'b0;
      no_cap();
      n_checks++;
      if (rec_valid !== 1'b0 || drop_cnt !== 4'd0 || overflow !== 1'b0)
         $display("FAIL clr_post: got v %b drop %0d ovf %b want 0 0 0",
                  rec_valid, drop_cnt, overflow);
      else n_pass++;
      drive_cap(32'h704, 32'h0);
      step();
      no_cap();
      n_checks++;
      if (rec_valid !== 1'b1 || rec_seq !== 16'd12 || rec_pc !== 32'h704)
         $display("FAIL clr_seq: got v %b seq %0d pc %h want 1 12 704", rec_valid, rec_seq, rec_pc);
      else n_pass++;
   endtask

   task automatic test_wrap();
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      exp_a = INSTR_EN ? 32'hDEAD_BEEF : 32'h0;
      exp_b = INSTR_EN ? 32'h0000_0000 : 32'h0;
      apply_reset();
      for (int i = 0; i < 255; i++) step();
      drive_cap(32'h800, 32'hDEAD_BEEF);
      step();
      drive_cap(32'h804, 32'h0000_0000);
      step();
      no_cap();
      n_checks++;
      if (rec_cycle !== 8'hFF || rec_instr !== exp_a)
         $display("FAIL wrap_hi: got cyc %h instr %h want ff %h", rec_cycle, rec_instr, exp_a);
      else n_pass++;
      rec_ready = 1'b1;
      step();
      rec_ready = 1'b0;
      n_checks++;
      if (rec_valid !== 1'b1 || rec_cycle !== 8'h00 || rec_instr !== exp_b || rec_pc !== 32'h804)
         $display("FAIL wrap_lo: got v %b cyc %h instr %h pc %h want 1 00 %h 804",
                  rec_valid, rec_cycle, rec_instr, rec_pc, exp_b);
      else n_pass++;
   endtask

   task automatic test_random();
      logic               e_v;
      logic [31:0]        e_pc;
      logic [CYCLE_W-1:0] e_cyc;
      logic [15:0]        e_seq;
      logic [31:0]        e_instr;
      int                 errs;
      apply_reset();
      errs = 0;
      for (int i = 0; i < 3000; i++) begin
         rst_n      = ($urandom_range(0, 499) != 0);
         wb_valid   = $urandom_range(0, 3) != 0;
         wb_illegal = $urandom_range(0, 1);
         wb_pc      = $urandom;
         wb_instr   = $urandom;
         clear      = ($urandom_range(0, 63) == 0);
         rec_ready  = ($urandom_range(0, 2) == 0);
         step();
         e_v     = mq.size() > 0;
         e_pc    = e_v ? mq[0].pc : 32'h0;
         e_cyc   = e_v ? CYCLE_W'(mq[0].cyc) : '0;
         e_seq   = e_v ? 16'(mq[0].seq) : 16'h0;
         e_instr = e_v ? mq[0].instr : 32'h0;
         n_checks++;
         if (rec_valid !== e_v || rec_pc !== e_pc || rec_cycle !== e_cyc ||
             rec_seq !== e_seq || rec_instr !== e_instr) begin
            if (errs < 10)
               $display("FAIL rnd_rec @%0d: got v%b pc %h cyc %h seq %0d ins %h want v%b pc %h cyc %h seq %0d ins %h",
                        i, rec_valid, rec_pc, rec_cycle, rec_seq, rec_instr,
                        e_v, e_pc, e_cyc, e_seq, e_instr);
            errs++;
         end else n_pass++;
         n_checks++;
         if (drop_cnt !== DROP_W'(m_drop) || overflow !== m_ovf) begin
            if (errs < 10)
               $display("FAIL rnd_drop @%0d: got drop %0d ovf %b want %0d %b",
                        i, drop_cnt, overflow, m_drop, m_ovf);
            errs++;
         end else n_pass++;
      end
      rst_n = 1'b1;
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      test_reset();
      test_single();
      test_overflow();
      test_full_pushpop();
      test_legal_only();
      test_saturate();
      test_clear();
      test_wrap();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
